// File: rtl/feature_map_axis_tx.sv
// Streams a stored feature map row-major as an AXI4-Stream frame (TUSER = SOF, TLAST = EOL).
// First beat 3 cycles after start; a 2-entry buffer absorbs read latency and holds beats under TREADY=0.
module feature_map_axis_tx #(
  parameter int DATA_WIDTH         = 16,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int IMG_WIDTH          = 32,
  parameter int IMG_HEIGHT         = 32,
  parameter int ADDR_WIDTH         = 14
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            rd_en,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            m00_axis_tvalid,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  output logic                            m00_axis_tuser,
  input  logic                            m00_axis_tready
);

  localparam int N     = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int EW    = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_q;
  logic                  busy_q, done_q;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [COL_W-1:0]      rd_col_q, rd_col_d;
  logic                  inflight_q;
  logic [1:0]            inflight_flags_q;
  logic [EW-1:0]         ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  pop, push, last_rd;
  logic [2:0]            pending;
  logic [EW-1:0]         push_ent;

  assign pop      = m00_axis_tvalid && m00_axis_tready;
  assign push     = inflight_q;
  assign push_ent = {rd_data, inflight_flags_q};
  // Reads in the buffer or on their way back, after this cycle's pop, must stay below two.
  assign pending  = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign rd_en    = (state_q == RUN) && (pending < 3'd2);
  assign last_rd  = (rd_cnt_q == ADDR_WIDTH'(N - 1));
  assign rd_addr  = rd_cnt_q;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    rd_col_d = rd_col_q;
    if (rd_en) begin
      rd_cnt_d = last_rd ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
      rd_col_d = (rd_col_q == COL_W'(IMG_WIDTH - 1)) ? '0 : rd_col_q + COL_W'(1);
    end
  end

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_ent;
        else               ent1_d = push_ent;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_ent;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_ent;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q         <= '0;
      rd_col_q         <= '0;
      inflight_q       <= 1'b0;
      inflight_flags_q <= 2'b00;
      ent0_q           <= '0;
      ent1_q           <= '0;
      occ_q            <= 2'd0;
    end else begin
      rd_cnt_q         <= rd_cnt_d;
      rd_col_q         <= rd_col_d;
      inflight_q       <= rd_en;
      inflight_flags_q <= {rd_cnt_q == '0, rd_col_q == COL_W'(IMG_WIDTH - 1)};
      ent0_q           <= ent0_d;
      ent1_q           <= ent1_d;
      occ_q            <= occ_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
        RUN: if (rd_en && last_rd) state_q <= DRAIN;
        // Leave as the final beat is accepted so done lands on the following cycle.
        DRAIN: if (occ_d == 2'd0) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign m00_axis_tvalid = (occ_q != 2'd0);
  assign m00_axis_tdata  = m00_axis_tvalid ? C_AXIS_TDATA_WIDTH'(ent0_q[EW-1:2]) : '0;
  assign m00_axis_tuser  = m00_axis_tvalid && ent0_q[1];
  assign m00_axis_tlast  = m00_axis_tvalid && ent0_q[0];
  assign m00_axis_tstrb  = {(C_AXIS_TDATA_WIDTH/8){m00_axis_tvalid}};

endmodule

// File: tb/tb_feature_map_axis_tx.sv
// Directed bench: 4x2 frame (timing, backpressure, start masking, mid-frame reset), 32x32 random-ready frame, 1x1 frame.
module tb_feature_map_axis_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 0, busy_a, done_a, rd_en_a, tvalid_a, tlast_a, tuser_a, tready_a = 0;
  logic [13:0] rd_addr_a;
  logic [15:0] rd_data_a;
  logic [31:0] tdata_a;
  logic [3:0]  tstrb_a;

  logic        start_b = 0, busy_b, done_b, rd_en_b, tvalid_b, tlast_b, tuser_b, tready_b = 0;
  logic [13:0] rd_addr_b;
  logic [15:0] rd_data_b;
  logic [31:0] tdata_b;
  logic [3:0]  tstrb_b;

  logic        start_c = 0, busy_c, done_c, rd_en_c, tvalid_c, tlast_c, tuser_c, tready_c = 0;
  logic [13:0] rd_addr_c;
  logic [15:0] rd_data_c;
  logic [31:0] tdata_c;
  logic [3:0]  tstrb_c;

  feature_map_axis_tx #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .m00_axis_tvalid(tvalid_a), .m00_axis_tdata(tdata_a), .m00_axis_tstrb(tstrb_a),
    .m00_axis_tlast(tlast_a), .m00_axis_tuser(tuser_a), .m00_axis_tready(tready_a));

  feature_map_axis_tx #(.IMG_WIDTH(32), .IMG_HEIGHT(32)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .m00_axis_tvalid(tvalid_b), .m00_axis_tdata(tdata_b), .m00_axis_tstrb(tstrb_b),
    .m00_axis_tlast(tlast_b), .m00_axis_tuser(tuser_b), .m00_axis_tready(tready_b));

  feature_map_axis_tx #(.IMG_WIDTH(1), .IMG_HEIGHT(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
    .m00_axis_tvalid(tvalid_c), .m00_axis_tdata(tdata_c), .m00_axis_tstrb(tstrb_c),
    .m00_axis_tlast(tlast_c), .m00_axis_tuser(tuser_c), .m00_axis_tready(tready_c));

  function automatic logic [15:0] mem_a(input logic [13:0] ad);
    return 16'h0100 + 16'(ad);
  endfunction
  function automatic logic [15:0] mem_b(input logic [13:0] ad);
    return 16'h1000 + 16'(ad) * 16'd3;
  endfunction

  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? mem_a(rd_addr_a) : 16'hDEAD;
    rd_data_b <= rd_en_b ? mem_b(rd_addr_b) : 16'hDEAD;
    rd_data_c <= rd_en_c ? 16'hFFFF : 16'hDEAD;
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance A observations
  logic [31:0] a_dat[$];
  int a_usr[$], a_lst[$], a_bcyc[$], a_rdaddr[$], a_done[$];
  int a_rd_first, a_busy_first, a_busy_last, a_out, a_max_out, a_stab_err;
  logic a_stall;
  logic [37:0] a_hold;

  // Instance B observations
  int b_idx, b_err, b_usr, b_lst, b_ndone, b_out, b_max_out, b_stab_err;
  logic b_stall;
  logic [37:0] b_hold;

  // Instance C observations
  logic [31:0] c_dat[$];
  int c_strb[$], c_usr[$], c_lst[$], c_bcyc[$], c_done[$], c_rdaddr[$];

  task automatic a_clear();
    a_dat.delete(); a_usr.delete(); a_lst.delete(); a_bcyc.delete();
    a_rdaddr.delete(); a_done.delete();
    a_rd_first = -1; a_busy_first = -1; a_busy_last = -1;
    a_out = 0; a_max_out = 0; a_stab_err = 0; a_stall = 0; a_hold = '0;
  endtask

  task automatic sample_all();
    if (!reset) begin
      if (rd_en_a) begin
        a_rdaddr.push_back(int'(rd_addr_a));
        if (a_rd_first < 0) a_rd_first = cyc;
      end
      if (tvalid_a && tready_a) begin
        a_dat.push_back(tdata_a); a_usr.push_back(int'(tuser_a));
        a_lst.push_back(int'(tlast_a)); a_bcyc.push_back(cyc);
      end
      a_out = a_out + int'(rd_en_a) - int'(tvalid_a && tready_a);
      if (a_out > a_max_out) a_max_out = a_out;
      if (a_stall && (!tvalid_a || a_hold != {tdata_a, tstrb_a, tuser_a, tlast_a})) a_stab_err++;
      a_stall = tvalid_a && !tready_a;
      a_hold  = {tdata_a, tstrb_a, tuser_a, tlast_a};
      if (done_a) a_done.push_back(cyc);
      if (busy_a) begin
        if (a_busy_first < 0) a_busy_first = cyc;
        a_busy_last = cyc;
      end

      if (tvalid_b && tready_b) begin
        if (tdata_b !== {16'h0, mem_b(14'(b_idx))}) b_err++;
        if (tuser_b !== (b_idx == 0)) b_err++;
        if (tlast_b !== (b_idx % 32 == 31)) b_err++;
        if (tstrb_b !== 4'hF) b_err++;
        b_usr += int'(tuser_b); b_lst += int'(tlast_b); b_idx++;
      end
      b_out = b_out + int'(rd_en_b) - int'(tvalid_b && tready_b);
      if (b_out > b_max_out) b_max_out = b_out;
      if (b_stall && (!tvalid_b || b_hold != {tdata_b, tstrb_b, tuser_b, tlast_b})) b_stab_err++;
      b_stall = tvalid_b && !tready_b;
      b_hold  = {tdata_b, tstrb_b, tuser_b, tlast_b};
      if (done_b) b_ndone++;

      if (rd_en_c) c_rdaddr.push_back(int'(rd_addr_c));
      if (tvalid_c && tready_c) begin
        c_dat.push_back(tdata_c); c_strb.push_back(int'(tstrb_c));
        c_usr.push_back(int'(tuser_c)); c_lst.push_back(int'(tlast_c)); c_bcyc.push_back(cyc);
      end
      if (done_c) c_done.push_back(cyc);
    end
  endtask

  // One cycle: sample mid-cycle, then land 1 time unit after the next rising edge.
  task automatic step();
    @(negedge clk);
    sample_all();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_a_frame(output int t0);
    start_a = 1; t0 = cyc; step(); start_a = 0;
    for (int k = 0; k < 60 && a_done.size() == 0; k++) step();
    step(); step();
  endtask

  int t0;

  initial begin
    a_clear();
    b_idx = 0; b_err = 0; b_usr = 0; b_lst = 0; b_ndone = 0;
    b_out = 0; b_max_out = 0; b_stab_err = 0; b_stall = 0; b_hold = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", tvalid_a, 0);
    chk("rst_rd_en", rd_en_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tdata", tdata_a, 0);
    chk("rst_tstrb", tstrb_a, 0);
    reset = 0;
    step();

    // 4x2 frame, tready held high
    a_clear(); tready_a = 1;
    run_a_frame(t0);
    chk("t1_beats", a_dat.size(), 8);
    for (int i = 0; i < a_dat.size() && i < 8; i++) begin
      chk("t1_data", a_dat[i], 32'h100 + i);
      chk("t1_beat_cyc", a_bcyc[i], t0 + 3 + i);
      chk("t1_tuser", a_usr[i], (i == 0) ? 1 : 0);
      chk("t1_tlast", a_lst[i], (i == 3 || i == 7) ? 1 : 0);
    end
    chk("t1_done_cnt", a_done.size(), 1);
    if (a_done.size() > 0) chk("t1_done_cyc", a_done[0], t0 + 11);
    chk("t1_rd_cnt", a_rdaddr.size(), 8);
    for (int i = 0; i < a_rdaddr.size() && i < 8; i++) chk("t1_rd_addr", a_rdaddr[i], i);
    chk("t1_rd_first", a_rd_first, t0 + 1);
    chk("t1_busy_first", a_busy_first, t0 + 1);
    chk("t1_busy_last", a_busy_last, t0 + 11);

    // Same frame, tready low for 5 cycles from beat 2
    a_clear();
    start_a = 1; t0 = cyc; step(); start_a = 0;
    for (int k = 0; k < 60 && a_done.size() == 0; k++) begin
      tready_a = !(cyc >= t0 + 5 && cyc < t0 + 10);
      step();
    end
    tready_a = 1; step();
    chk("t2_beats", a_dat.size(), 8);
    for (int i = 0; i < a_dat.size() && i < 8; i++) chk("t2_data", a_dat[i], 32'h100 + i);
    if (a_bcyc.size() > 2) chk("t2_beat2_cyc", a_bcyc[2], t0 + 10);
    chk("t2_stable", a_stab_err, 0);
    chk("t2_outstanding_le2", a_max_out <= 2, 1);
    chk("t2_done_cnt", a_done.size(), 1);
    if (a_done.size() > 0) chk("t2_done_cyc", a_done[0], t0 + 16);

    // Stray start pulses at beats 1 and 5 and during DONE
    a_clear();
    start_a = 1; t0 = cyc; step(); start_a = 0;
    for (int k = 0; k < 30; k++) begin
      start_a = (cyc == t0 + 4 || cyc == t0 + 8 || cyc == t0 + 11);
      step();
    end
    start_a = 0;
    chk("t4_beats", a_dat.size(), 8);
    chk("t4_done_cnt", a_done.size(), 1);
    chk("t4_rd_cnt", a_rdaddr.size(), 8);
    chk("t4_busy_last", a_busy_last, t0 + 11);

    // Reset mid-frame while beat 3 is presented
    a_clear();
    start_a = 1; t0 = cyc; step(); start_a = 0;
    for (int k = 0; k < 10 && cyc < t0 + 6; k++) step();
    chk("t5_pre_tdata", tdata_a, 32'h103);
    reset = 1;
    #1;
    chk("t5_tvalid", tvalid_a, 0);
    chk("t5_tlast", tlast_a, 0);
    chk("t5_tuser", tuser_a, 0);
    chk("t5_tdata", tdata_a, 0);
    chk("t5_tstrb", tstrb_a, 0);
    chk("t5_rd_en", rd_en_a, 0);
    chk("t5_rd_addr", rd_addr_a, 0);
    chk("t5_busy", busy_a, 0);
    chk("t5_done", done_a, 0);
    step(); step();
    reset = 0;
    step();
    chk("t5_idle_busy", busy_a, 0);
    chk("t5_idle_tvalid", tvalid_a, 0);
    a_clear();
    run_a_frame(t0);
    chk("t5_beats", a_dat.size(), 8);
    for (int i = 0; i < a_dat.size() && i < 8; i++) chk("t5_data", a_dat[i], 32'h100 + i);
    if (a_usr.size() > 0) chk("t5_tuser0", a_usr[0], 1);
    if (a_done.size() > 0) chk("t5_done_cyc", a_done[0], t0 + 11);
    else chk("t5_done_cnt", a_done.size(), 1);

    // 32x32 frame with random tready
    start_b = 1; tready_b = 1'($urandom_range(0, 1)); step(); start_b = 0;
    for (int k = 0; k < 8000 && b_ndone == 0; k++) begin
      tready_b = 1'($urandom_range(0, 1));
      step();
    end
    tready_b = 1; step();
    chk("t3_beats", b_idx, 1024);
    chk("t3_content_err", b_err, 0);
    chk("t3_tlast_cnt", b_lst, 32);
    chk("t3_tuser_cnt", b_usr, 1);
    chk("t3_stable", b_stab_err, 0);
    chk("t3_outstanding_le2", b_max_out <= 2, 1);
    chk("t3_done_cnt", b_ndone, 1);

    // 1x1 frame with all-ones data
    tready_c = 1; start_c = 1; t0 = cyc; step(); start_c = 0;
    for (int k = 0; k < 20 && c_done.size() == 0; k++) step();
    step();
    chk("t6_beats", c_dat.size(), 1);
    if (c_dat.size() > 0) begin
      chk("t6_tdata", c_dat[0], 32'h0000FFFF);
      chk("t6_tstrb", c_strb[0], 4'hF);
      chk("t6_tuser", c_usr[0], 1);
      chk("t6_tlast", c_lst[0], 1);
      chk("t6_beat_cyc", c_bcyc[0], t0 + 3);
    end
    chk("t6_done_cnt", c_done.size(), 1);
    if (c_done.size() > 0) chk("t6_done_cyc", c_done[0], t0 + 4);
    chk("t6_rd_cnt", c_rdaddr.size(), 1);
    if (c_rdaddr.size() > 0) chk("t6_rd_addr", c_rdaddr[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
